thumb_fetch_unit: RTL and testbench
===================================

// Module: thumb_fetch_unit
// PURPOSE
//  Instruction-fetch front end of the ARMSOC Cortex-M0-style core; drives the address of the combinational
//  16-bit instruction memory and buffers returned halfwords in a prefetch queue. Delivers them in order,
//  each tagged with its PC, to the decoder over a valid/ready handshake. Branch redirects flush the queue.
// PARAMETERS
//  DEPTH     4      prefetch queue entries; power of two, >= 2
//  RESET_PC  32'h0  first fetch address after reset; bit 0 ignored
// PORTS
//  clk           in   1   single clock; all state on rising edge
//  reset_n       in   1   asynchronous, active-low reset
//  imem_addr     out  32  byte address to instruction memory; bit 0 always 0
//  imem_rd       in   16  halfword at imem_addr, valid in the same cycle (combinational memory)
//  instr_valid   out  1   head of queue holds a deliverable instruction
//  instr_ready   in   1   decoder accepts instruction this cycle
//  instr         out  32  instruction; 16-bit ops in [15:0], [31:16]=0
//  instr_is32    out  1   instr holds a 32-bit BL pair (macro only; else 0)
//  instr_pc      out  32  byte address of instr (first halfword)
//  redirect_valid in  1   branch taken; flush and refetch
//  redirect_pc   in   32  branch target; bit 0 discarded
// BEHAVIOUR
//  - Reset (async assert, sync release): fetch_pc=RESET_PC&~1, queue empty, instr_valid=0, instr=0,
//    instr_is32=0, instr_pc=0. imem_addr = fetch_pc combinationally, so equals RESET_PC&~1 during reset.
//  - Push: each cycle with no redirect and (count<DEPTH or a pop this cycle), {fetch_pc, imem_rd} enters
//    the tail; fetch_pc += 2, mod 2^32 (0xFFFFFFFE wraps to 0). Otherwise fetch_pc holds.
//  - Pop: when instr_valid && instr_ready, head entry (or pair) leaves. Full queue with a pop also pushes,
//    so a ready-high decoder gets one halfword per cycle.
//  - Latency: halfword fetched in cycle N is visible at instr in cycle N+1. First instr_valid is the
//    second rising edge after reset release.
//  - Outputs are driven from queue head registers; instr/instr_pc are stable while valid && !ready.
//  - Redirect in cycle N: instr_valid forced 0 combinationally in cycle N, so no pop occurs. No push.
//    Queue cleared at edge; fetch_pc <= redirect_pc&~1. Target fetched in N+1, valid in N+2.
//  - Redirect has priority over push, pop and pairing; back-to-back redirects: last one wins.
//  - Empty queue: instr_valid=0; instr/instr_pc hold last value, don't-care for checking.
//  - count held 0..DEPTH; pointers wrap modulo DEPTH. No overflow or underflow is possible by construction.
// CONFIGURATION
//  THUMB_FETCH_BL_PAIR_EN defined:
//    - Head halfword with [15:11]==5'b11110 is a BL prefix. It is valid only when its suffix is also queued
//      (count>=2); it then delivers instr={prefix,suffix}, instr_is32=1 and pops both.
//    - The queue is never full of a lone prefix: DEPTH>=2 guarantees the suffix fits.
//  Not defined: every halfword is delivered singly, instr_is32 tied 0, prefix gets no special treatment.
// STRUCTURE
//  Package thumb_fetch_pkg holds:
//    - typedef struct packed {logic [31:0] pc; logic [15:0] hw;} fetch_entry_t
//    - localparam BL_PREFIX=5'b11110
//    - HW_BYTES=2
//  Sub-module fetch_queue: DEPTH-entry fetch_entry_t FIFO with push/pop/flush, count, head and head+1
//  outputs. The top holds fetch_pc, push/pop arbitration, redirect and optional pairing.
// TESTING
//  Default imem image: ROM[0]=E006, ROM[1]=E005, ROM[2]=0051, ROM[20]=6846.
//  1 Reset release, ready=1 -> valid on 2nd edge; stream E006@0, E005@2, 0051@4, one per cycle, no gaps.
//  2 ready=0 after reset -> queue fills to 4 entries; imem_addr holds at 0x8; head stays E006@0 while
//    stalled; raise ready -> 0x0..0x6 delivered in order.
//  3 redirect_valid with redirect_pc=0x29 while streaming -> instr_valid=0 that cycle; next delivered is
//    6846@0x28 two cycles later; no stale entries appear.
//  4 Redirect to 0xFFFFFFFE (bench image) -> delivers pc 0xFFFFFFFE then pc 0x0; fetch_pc wraps cleanly.
//  5 BL pair, macro on: bench image F000@0x10, F802@0x12 -> instr=32'hF000F802, is32=1, pc=0x10, one pop.
//    Macro off: F000 then F802 delivered separately.
//  6 reset_n low mid-stream with full queue -> all outputs 0 immediately, async; refetch from RESET_PC.

Source files
------------

// File: rtl/thumb_fetch_pkg.sv
// Shared types and constants for the Thumb instruction-fetch front end.
package thumb_fetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [15:0] hw;
    } fetch_entry_t;

    localparam logic [4:0]  BL_PREFIX = 5'b11110;
    localparam logic [31:0] HW_BYTES  = 32'd2;

    function automatic logic is_bl_prefix(input logic [15:0] hw);
        return (hw[15:11] == BL_PREFIX);
    endfunction

endpackage

// File: rtl/thumb_fetch_unit_fetch_queue.sv
// Prefetch FIFO of {pc, halfword} entries; pops one or two entries per cycle, flush empties it.
module fetch_queue
    import thumb_fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  fetch_entry_t               push_entry_i,
    input  logic                       pop_i,
    input  logic                       pop2_i,
    output logic [$clog2(DEPTH):0]     count_o,
    output fetch_entry_t               head_o,
    output logic [15:0]                head_next_hw_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] pop_n_s;
    logic [PW-1:0] next_ptr_s;

    // Pointer and occupancy next-state; flush wins over any push or pop.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (pop2_i) begin
            pop_n_s = CW'(2'd2);
        end else if (pop_i) begin
            pop_n_s = CW'(1'b1);
        end else begin
            pop_n_s = {CW{1'b0}};
        end
        if (flush_i) begin
            rd_ptr_d = {PW{1'b0}};
            wr_ptr_d = {PW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            rd_ptr_d = rd_ptr_q + pop_n_s[PW-1:0];
            wr_ptr_d = wr_ptr_q + PW'(push_i);
            count_d  = count_q + CW'(push_i) - pop_n_s;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q <= {PW{1'b0}};
            wr_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; cleared on reset so the head reads as all-zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '{pc: 32'h0000_0000, hw: 16'h0000};
            end
        end else if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= push_entry_i;
        end
    end

    assign next_ptr_s     = rd_ptr_q + PW'(1'b1);
    assign count_o        = count_q;
    assign head_o         = mem_q[rd_ptr_q];
    assign head_next_hw_o = mem_q[next_ptr_s].hw;

endmodule

// File: rtl/thumb_fetch_unit.sv
// Thumb fetch front end: fetch PC, prefetch queue arbitration and branch redirect.
// Define THUMB_FETCH_BL_PAIR_EN to deliver BL prefix/suffix halfwords as one 32-bit instruction.
module thumb_fetch_unit
    import thumb_fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [31:0] imem_addr,
    input  logic [15:0] imem_rd,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic        instr_is32,
    output logic [31:0] instr_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int            CW             = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_COUNT     = CW'(DEPTH);
    localparam logic [CW-1:0] PAIR_COUNT     = CW'(2'd2);
    localparam logic [31:0]   RESET_FETCH_PC = {RESET_PC[31:1], 1'b0};

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] count_s;
    fetch_entry_t  head_s;
    fetch_entry_t  push_entry_s;
    logic [15:0]   head_next_hw_s;
    logic          head_is_prefix_s;
    logic          push_s, pop_s, pop2_s;

`ifdef THUMB_FETCH_BL_PAIR_EN
    assign head_is_prefix_s = is_bl_prefix(head_s.hw);
`else
    assign head_is_prefix_s = 1'b0;
`endif

    assign push_entry_s = '{pc: fetch_pc_q, hw: imem_rd};
    assign imem_addr    = fetch_pc_q;

    // Handshake and fetch arbitration; a redirect suppresses delivery, push and pop this cycle.
    always_comb begin
        instr_valid = 1'b0;
        pop_s       = 1'b0;
        pop2_s      = 1'b0;
        push_s      = 1'b0;
        fetch_pc_d  = fetch_pc_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & ~32'd1;
        end else begin
            // A BL prefix waits at the head until its suffix is queued behind it.
            instr_valid = (count_s != {CW{1'b0}}) &&
                          (!head_is_prefix_s || (count_s >= PAIR_COUNT));
            pop_s       = instr_valid && instr_ready;
            pop2_s      = pop_s && head_is_prefix_s;
            push_s      = (count_s != FULL_COUNT) || pop_s;
            if (push_s) begin
                fetch_pc_d = fetch_pc_q + HW_BYTES;
            end else begin
                fetch_pc_d = fetch_pc_q;
            end
        end
    end

    // Instruction payload straight from the queue head registers.
    always_comb begin
        instr_pc   = head_s.pc;
        instr_is32 = head_is_prefix_s;
        if (head_is_prefix_s) begin
            instr = {head_s.hw, head_next_hw_s};
        end else begin
            instr = {16'h0000, head_s.hw};
        end
    end

    // Fetch program counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc_q <= RESET_FETCH_PC;
        end else begin
            fetch_pc_q <= fetch_pc_d;
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk            (clk),
        .reset_n        (reset_n),
        .flush_i        (redirect_valid),
        .push_i         (push_s),
        .push_entry_i   (push_entry_s),
        .pop_i          (pop_s),
        .pop2_i         (pop2_s),
        .count_o        (count_s),
        .head_o         (head_s),
        .head_next_hw_o (head_next_hw_s)
    );

endmodule

// File: tb/tb_thumb_fetch_unit.sv
// Self-checking bench for thumb_fetch_unit against a queue-of-PCs reference model.
module tb_thumb_fetch_unit;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic        valid;
        logic        is32;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] addr;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] imem_addr;
    logic [15:0] imem_rd;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic        instr_is32;
    logic [31:0] instr_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] mq[$];
    logic [31:0] mf = 32'h0;
    logic        m_valid, m_pair;

    always #5 clk = ~clk;

    thumb_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .imem_addr      (imem_addr),
        .imem_rd        (imem_rd),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_is32     (instr_is32),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    function automatic logic [15:0] rom(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 16'hE006;
            32'h0000_0002: return 16'hE005;
            32'h0000_0004: return 16'h0051;
            32'h0000_0010: return 16'hF000;
            32'h0000_0012: return 16'hF802;
            32'h0000_0028: return 16'h6846;
            default:       return {1'b0, a[15:1]};
        endcase
    endfunction

    function automatic logic is_prefix(input logic [15:0] hw);
`ifdef THUMB_FETCH_BL_PAIR_EN
        return hw[15:11] == 5'b11110;
`else
        return 1'b0;
`endif
    endfunction

    always_comb imem_rd = rom(imem_addr);

    // Drive one cycle of inputs at the falling edge and predict outputs for that cycle.
    task automatic predict(input logic rdy, input logic redir, input logic [31:0] tgt, output exp_t e);
        logic [15:0] h0;
        int sz;
        @(negedge clk);
        instr_ready = rdy;
        redirect_valid = redir;
        redirect_pc = tgt;
        sz = mq.size();
        h0 = 16'h0;
        e.pc = 32'h0;
        if (sz > 0) begin
            e.pc = mq[0];
            h0 = rom(mq[0]);
        end
        m_pair = (sz > 0) && is_prefix(h0);
        m_valid = !redir && (sz > 0) && (!m_pair || sz >= 2);
        e.valid = m_valid;
        e.is32 = m_valid && m_pair;
        e.instr = m_pair ? {h0, rom(e.pc + 32'd2)} : {16'h0, h0};
        e.addr = mf;
        #1;
    endtask

    // Advance the reference model across the rising edge.
    task automatic advance();
        int sz;
        logic popped;
        @(posedge clk);
        if (redirect_valid) begin
            mq.delete();
            mf = redirect_pc & ~32'd1;
        end else begin
            sz = mq.size();
            popped = m_valid && instr_ready;
            if (popped) begin
                void'(mq.pop_front());
                if (m_pair) void'(mq.pop_front());
            end
            if (sz < DEPTH || popped) begin
                mq.push_back(mf);
                mf = mf + 32'd2;
            end
        end
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        instr_ready = 1'b0;
        redirect_valid = 1'b0;
        mq.delete();
        mf = 32'h0;
        @(posedge clk);
        #2 reset_n = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        n_vec += 5;
        if (instr_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
        if (instr !== 32'h0) begin n_err++; $display("FAIL reset_instr: got %h want 0", instr); end
        if (instr_is32 !== 1'b0) begin n_err++; $display("FAIL reset_is32: got %b want 0", instr_is32); end
        if (instr_pc !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h want 0", instr_pc); end
        if (imem_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
        @(posedge clk);
        #2 reset_n = 1'b1;
    endtask

    task automatic test_stream();
        exp_t e;
        for (int i = 0; i < 10; i++) begin
            predict(1'b1, 1'b0, 32'h0, e);
            n_vec += 2;
            if (instr_valid !== e.valid) begin n_err++; $display("FAIL stream_valid: got %b want %b cyc %0d", instr_valid, e.valid, i); end
            if (imem_addr !== e.addr) begin n_err++; $display("FAIL stream_addr: got %h want %h", imem_addr, e.addr); end
            if (e.valid) begin
                n_vec++;
                if ({instr_is32, instr_pc, instr} !== {e.is32, e.pc, e.instr}) begin
                    n_err++; $display("FAIL stream_data: got %b/%h/%h want %b/%h/%h", instr_is32, instr_pc, instr, e.is32, e.pc, e.instr);
                end
            end
            advance();
        end
    endtask

    task automatic test_stall();
        exp_t e;
        apply_reset();
        for (int i = 0; i < 22; i++) begin
            predict(i >= 7, 1'b0, 32'h0, e);
            n_vec += 2;
            if (instr_valid !== e.valid) begin n_err++; $display("FAIL stall_valid: got %b want %b cyc %0d", instr_valid, e.valid, i); end
            if (imem_addr !== e.addr) begin n_err++; $display("FAIL stall_addr: got %h want %h", imem_addr, e.addr); end
            if (e.valid) begin
                n_vec++;
                if ({instr_is32, instr_pc, instr} !== {e.is32, e.pc, e.instr}) begin
                    n_err++; $display("FAIL stall_data: got %b/%h/%h want %b/%h/%h", instr_is32, instr_pc, instr, e.is32, e.pc, e.instr);
                end
            end
            advance();
            if (i == 6) begin
                #1;
                n_vec++;
                if ({imem_addr, instr_valid, instr_pc, instr} !== {32'h8, 1'b1, 32'h0, 32'h0000E006}) begin
                    n_err++; $display("FAIL stall_full: got addr %h v %b pc %h instr %h want 8/1/0/E006", imem_addr, instr_valid, instr_pc, instr);
                end
            end
        end
    endtask

    task automatic test_redirect(input string name, input logic [31:0] tgt, input logic [31:0] first_pc, input logic [31:0] first_instr);
        exp_t e;
        logic seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            predict(1'b1, i == 3, tgt, e);
            n_vec += 2;
            if (instr_valid !== e.valid) begin n_err++; $display("FAIL %s_valid: got %b want %b cyc %0d", name, instr_valid, e.valid, i); end
            if (imem_addr !== e.addr) begin n_err++; $display("FAIL %s_addr: got %h want %h", name, imem_addr, e.addr); end
            if (e.valid) begin
                n_vec++;
                if ({instr_is32, instr_pc, instr} !== {e.is32, e.pc, e.instr}) begin
                    n_err++; $display("FAIL %s_data: got %b/%h/%h want %b/%h/%h", name, instr_is32, instr_pc, instr, e.is32, e.pc, e.instr);
                end
                if (i > 3 && !seen) begin
                    seen = 1'b1;
                    n_vec++;
                    if ({instr_pc, instr} !== {first_pc, first_instr}) begin
                        n_err++; $display("FAIL %s_target: got %h/%h want %h/%h", name, instr_pc, instr, first_pc, first_instr);
                    end
                end
            end
            advance();
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            predict(1'b1, i < 2, (i == 0) ? 32'h40 : 32'h28, e);
            n_vec += 2;
            if (instr_valid !== e.valid) begin n_err++; $display("FAIL b2b_valid: got %b want %b cyc %0d", instr_valid, e.valid, i); end
            if (imem_addr !== e.addr) begin n_err++; $display("FAIL b2b_addr: got %h want %h", imem_addr, e.addr); end
            if (e.valid) begin
                n_vec++;
                if ({instr_is32, instr_pc, instr} !== {e.is32, e.pc, e.instr}) begin
                    n_err++; $display("FAIL b2b_data: got %b/%h/%h want %b/%h/%h", instr_is32, instr_pc, instr, e.is32, e.pc, e.instr);
                end
            end
            advance();
        end
    endtask

    task automatic test_random();
        exp_t e;
        logic [31:0] tgt;
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0: tgt = $urandom;
                1: tgt = 32'h10 | 32'($urandom_range(0, 1));
                2: tgt = 32'hFFFF_FFF8;
                default: tgt = 32'($urandom_range(0, 63));
            endcase
            predict($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 6, tgt, e);
            n_vec += 2;
            if (instr_valid !== e.valid) begin n_err++; $display("FAIL rand_valid: got %b want %b cyc %0d", instr_valid, e.valid, i); end
            if (imem_addr !== e.addr) begin n_err++; $display("FAIL rand_addr: got %h want %h", imem_addr, e.addr); end
            if (e.valid) begin
                n_vec++;
                if ({instr_is32, instr_pc, instr} !== {e.is32, e.pc, e.instr}) begin
                    n_err++; $display("FAIL rand_data: got %b/%h/%h want %b/%h/%h", instr_is32, instr_pc, instr, e.is32, e.pc, e.instr);
                end
            end
            advance();
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            predict(1'b0, 1'b0, 32'h0, e);
            advance();
        end
        #3 reset_n = 1'b0;
        #1;
        n_vec += 2;
        if ({instr_valid, instr_is32, instr, instr_pc} !== 66'h0) begin
            n_err++; $display("FAIL areset_out: got %b/%b/%h/%h want all 0", instr_valid, instr_is32, instr, instr_pc);
        end
        if (imem_addr !== 32'h0) begin n_err++; $display("FAIL areset_addr: got %h want 0", imem_addr); end
        mq.delete();
        mf = 32'h0;
        @(posedge clk);
        #2 reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            predict(1'b1, 1'b0, 32'h0, e);
            n_vec += 2;
            if (instr_valid !== e.valid) begin n_err++; $display("FAIL areset_valid: got %b want %b cyc %0d", instr_valid, e.valid, i); end
            if (imem_addr !== e.addr) begin n_err++; $display("FAIL areset_refetch: got %h want %h", imem_addr, e.addr); end
            if (e.valid) begin
                n_vec++;
                if ({instr_is32, instr_pc, instr} !== {e.is32, e.pc, e.instr}) begin
                    n_err++; $display("FAIL areset_data: got %b/%h/%h want %b/%h/%h", instr_is32, instr_pc, instr, e.is32, e.pc, e.instr);
                end
            end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect("redir", 32'h29, 32'h28, 32'h0000_6846);
        test_redirect("wrap", 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'h0000_7FFF);
`ifdef THUMB_FETCH_BL_PAIR_EN
        test_redirect("blpair", 32'h10, 32'h10, 32'hF000_F802);
`else
        test_redirect("blpair", 32'h10, 32'h10, 32'h0000_F000);
`endif
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
